// File: rtl/ras_fifo_ckpt.sv
// Return-address FIFO with checkpointed read pointer: popped entries stay resident
// until committed, so a flush can rewind the read pointer and replay them.
module ras_fifo_ckpt #(
    parameter int DEPTH    = 1024,
    parameter int WIDTH    = 36,
    parameter int BYPASS   = 1,
    parameter int AF_LEVEL = DEPTH - 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    input  logic                     commit,
    input  logic                     rewind,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic                     udf
);

    localparam int ADDR = $clog2(DEPTH);
    localparam int PW   = ADDR + 1;
    localparam logic [PW-1:0] DEPTH_PW = PW'(DEPTH);
    localparam logic [PW-1:0] AF_PW    = PW'(AF_LEVEL);
    localparam logic          BYP      = (BYPASS != 0);

    logic [WIDTH-1:0] ram [DEPTH];

    logic [PW-1:0] waddr, raddr, mark;
    logic [PW-1:0] waddr_n, raddr_n, mark_n, held_n;
    logic          push_ok, pop_ok;

    // Next-state pointers; rewind overrides both the same-cycle pop and commit.
    always_comb begin
        push_ok = push & ~full;
        pop_ok  = pop & ~rewind & (~empty | (BYP & push_ok));
        waddr_n = waddr + PW'(push_ok);
        raddr_n = rewind ? mark : (raddr + PW'(pop_ok));
        mark_n  = (commit & ~rewind) ? raddr_n : mark;
        held_n  = waddr_n - mark_n;
    end

    // Control state and flags, all derived from next-state pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            waddr       <= '0;
            raddr       <= '0;
            mark        <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            count       <= '0;
            ovf         <= 1'b0;
            udf         <= 1'b0;
        end else begin
            waddr       <= waddr_n;
            raddr       <= raddr_n;
            mark        <= mark_n;
            empty       <= (raddr_n == waddr_n);
            full        <= (held_n == DEPTH_PW);
            almost_full <= (held_n >= AF_PW);
            count       <= waddr_n - raddr_n;
            ovf         <= ovf | (push & full);
            udf         <= udf | (pop & ~pop_ok & ~rewind);
        end
    end

    // Storage is never reset; a bypassed entry is still written so rewind can replay it.
    always_ff @(posedge clk) begin
        if (push_ok)
            ram[waddr[ADDR-1:0]] <= din;
    end

    assign dout = (BYP && empty) ? din : ram[raddr[ADDR-1:0]];

endmodule

// File: tb/tb_ras_fifo_ckpt.sv
// Bench for ras_fifo_ckpt: a bypassing and a non-bypassing instance share stimulus
// and are checked every cycle against an integer-pointer model of the FIFO.
module tb_ras_fifo_ckpt;

    logic       clk;
    logic       rst;
    logic       push, pop, commit, rewind;
    logic [7:0] din;

    logic [7:0] dout  [2];
    logic       empty [2];
    logic       full  [2];
    logic       af    [2];
    logic [3:0] count [2];
    logic       ovf   [2];
    logic       udf   [2];

    int ncmp  = 0;
    int nfail = 0;

    ras_fifo_ckpt #(.DEPTH(8), .WIDTH(8), .BYPASS(1), .AF_LEVEL(6)) u_byp (
        .clk(clk), .rst(rst), .push(push), .din(din), .pop(pop), .dout(dout[0]),
        .commit(commit), .rewind(rewind), .empty(empty[0]), .full(full[0]),
        .almost_full(af[0]), .count(count[0]), .ovf(ovf[0]), .udf(udf[0]));

    ras_fifo_ckpt #(.DEPTH(8), .WIDTH(8), .BYPASS(0), .AF_LEVEL(6)) u_nob (
        .clk(clk), .rst(rst), .push(push), .din(din), .pop(pop), .dout(dout[1]),
        .commit(commit), .rewind(rewind), .empty(empty[1]), .full(full[1]),
        .almost_full(af[1]), .count(count[1]), .ovf(ovf[1]), .udf(udf[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Model: monotonic integer counters for written / read / committed entries.
    int         mw [2];
    int         mr [2];
    int         mm [2];
    bit         movf [2];
    bit         mudf [2];
    logic [7:0] mmem [2][8];

    task automatic model_step();
        for (int b = 0; b < 2; b++) begin
            bit is_full, push_ok, pop_ok;
            int nr;
            if (rst) begin
                mw[b] = 0; mr[b] = 0; mm[b] = 0; movf[b] = 0; mudf[b] = 0;
            end else begin
                is_full = (mw[b] - mm[b] == 8);
                push_ok = push && !is_full;
                pop_ok  = pop && !rewind && ((mr[b] < mw[b]) || (b == 0 && push_ok));
                if (push && is_full) movf[b] = 1;
                if (pop && !pop_ok && !rewind) mudf[b] = 1;
                if (push_ok) begin
                    mmem[b][mw[b] % 8] = din;
                    mw[b]++;
                end
                nr = rewind ? mm[b] : mr[b] + (pop_ok ? 1 : 0);
                if (commit && !rewind) mm[b] = nr;
                mr[b] = nr;
            end
        end
    endtask

    task automatic model_check();
        for (int b = 0; b < 2; b++) begin
            bit me;
            me = (mr[b] == mw[b]);
            chk($sformatf("u%0d empty", b), 32'(empty[b]), 32'(me));
            chk($sformatf("u%0d full", b), 32'(full[b]), 32'(mw[b] - mm[b] == 8));
            chk($sformatf("u%0d almost_full", b), 32'(af[b]), 32'(mw[b] - mm[b] >= 6));
            chk($sformatf("u%0d count", b), 32'(count[b]), 32'(mw[b] - mr[b]));
            chk($sformatf("u%0d ovf", b), 32'(ovf[b]), 32'(movf[b]));
            chk($sformatf("u%0d udf", b), 32'(udf[b]), 32'(mudf[b]));
            if (!me)
                chk($sformatf("u%0d dout", b), 32'(dout[b]), 32'(mmem[b][mr[b] % 8]));
            else if (b == 0)
                chk("u0 dout bypass", 32'(dout[0]), 32'(din));
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            model_check();
        end
    end

    task automatic set(input bit p, input logic [7:0] d, input bit po, input bit c, input bit rw);
        push = p; din = d; pop = po; commit = c; rewind = rw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        set(0, 8'h00, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;
        chk("reset empty", 32'(empty[0]), 32'd1);
        chk("reset count", 32'(count[0]), 32'd0);
        chk("reset full", 32'(full[0]), 32'd0);
        chk("reset almost_full", 32'(af[0]), 32'd0);

        // Fill to full, then one refused push
        for (int i = 0; i < 8; i++) begin
            set(1, 8'h11 + 8'(i), 0, 0, 0);
            tick();
            if (i == 4) chk("af after 5", 32'(af[0]), 32'd0);
            if (i == 5) chk("af after 6", 32'(af[0]), 32'd1);
        end
        chk("full after 8", 32'(full[0]), 32'd1);
        chk("count after 8", 32'(count[0]), 32'd8);
        set(1, 8'h99, 0, 0, 0);
        tick();
        chk("ovf after 9th", 32'(ovf[0]), 32'd1);
        chk("count after 9th", 32'(count[0]), 32'd8);
        chk("head after 9th", 32'(dout[0]), 32'h11);

        // Pop 3, commit frees slots, push lands in wrapped slot 0
        for (int i = 0; i < 3; i++) begin
            set(0, 8'h00, 1, 0, 0);
            #1 chk("pop dout", 32'(dout[0]), 32'h11 + 32'(i));
            tick();
        end
        chk("count after pop3", 32'(count[0]), 32'd5);
        chk("full kept after pop3", 32'(full[0]), 32'd1);
        set(0, 8'h00, 0, 1, 0);
        tick();
        chk("full after commit", 32'(full[0]), 32'd0);
        set(1, 8'h19, 0, 0, 0);
        tick();
        chk("count after 0x19", 32'(count[0]), 32'd6);
        for (int i = 0; i < 5; i++) begin
            set(0, 8'h00, 1, 0, 0);
            #1 chk("drain dout", 32'(dout[1]), 32'h14 + 32'(i));
            tick();
        end
        set(0, 8'h00, 1, 0, 0);
        #1 chk("wrapped slot dout", 32'(dout[1]), 32'h19);
        tick();
        chk("empty after drain", 32'(empty[1]), 32'd1);
        set(0, 8'h00, 0, 1, 0);
        tick();

        // Push A,B,C; pop 2; rewind; replay
        set(1, 8'hA1, 0, 0, 0); tick();
        set(1, 8'hB2, 0, 0, 0); tick();
        set(1, 8'hC3, 0, 0, 0); tick();
        set(0, 8'h00, 1, 0, 0); #1 chk("pop A", 32'(dout[0]), 32'hA1); tick();
        set(0, 8'h00, 1, 0, 0); #1 chk("pop B", 32'(dout[0]), 32'hB2); tick();
        set(0, 8'h00, 0, 0, 1);
        tick();
        chk("count after rewind", 32'(count[0]), 32'd3);
        chk("dout after rewind", 32'(dout[0]), 32'hA1);
        set(0, 8'h00, 1, 0, 0); #1 chk("replay A", 32'(dout[0]), 32'hA1); tick();
        set(0, 8'h00, 1, 0, 0); #1 chk("replay B", 32'(dout[0]), 32'hB2); tick();
        set(0, 8'h00, 1, 0, 0); #1 chk("replay C", 32'(dout[0]), 32'hC3); tick();
        set(0, 8'h00, 0, 1, 0);
        tick();

        // Bypass on empty, and the refused pop on the non-bypass instance
        set(1, 8'h5A, 1, 0, 0);
        #1 chk("bypass dout", 32'(dout[0]), 32'h5A);
        tick();
        chk("bypass empty", 32'(empty[0]), 32'd1);
        chk("bypass count", 32'(count[0]), 32'd0);
        chk("bypass udf", 32'(udf[0]), 32'd0);
        chk("nobypass udf", 32'(udf[1]), 32'd1);
        chk("nobypass count", 32'(count[1]), 32'd1);
        set(0, 8'h00, 0, 0, 1);
        tick();
        chk("bypass rewind count", 32'(count[0]), 32'd1);
        chk("bypass rewind dout", 32'(dout[0]), 32'h5A);
        set(0, 8'h00, 1, 1, 0);
        tick();

        // Rewind + commit + pop + push with two popped-uncommitted entries
        set(1, 8'hD1, 0, 0, 0); tick();
        set(1, 8'hD2, 0, 0, 0); tick();
        set(0, 8'h00, 1, 0, 0); tick();
        set(0, 8'h00, 1, 0, 0); tick();
        set(1, 8'hD3, 1, 1, 1);
        tick();
        chk("combo count", 32'(count[0]), 32'd3);
        chk("combo dout", 32'(dout[0]), 32'hD1);
        chk("combo udf", 32'(udf[0]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            set(0, 8'h00, 1, 0, 0);
            #1 chk("combo replay", 32'(dout[0]), 32'hD1 + 32'(i));
            tick();
        end
        set(0, 8'h00, 0, 1, 0);
        tick();

        // Stream through several pointer wraps, then fill again
        set(1, 8'h40, 0, 0, 0);
        tick();
        for (int i = 0; i < 20; i++) begin
            set(1, 8'h41 + 8'(i), 1, 1, 0);
            tick();
        end
        chk("stream count", 32'(count[0]), 32'd1);
        chk("stream dout", 32'(dout[0]), 32'h54);
        for (int i = 0; i < 7; i++) begin
            set(1, 8'h60 + 8'(i), 0, 0, 0);
            tick();
        end
        chk("refill full", 32'(full[0]), 32'd1);
        chk("refill count", 32'(count[0]), 32'd8);

        // Reset mid-stream with count=5
        for (int i = 0; i < 3; i++) begin
            set(0, 8'h00, 1, 0, 0);
            tick();
        end
        chk("pre-reset count", 32'(count[0]), 32'd5);
        set(0, 8'h00, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int b = 0; b < 2; b++) begin
            chk($sformatf("u%0d rst empty", b), 32'(empty[b]), 32'd1);
            chk($sformatf("u%0d rst count", b), 32'(count[b]), 32'd0);
            chk($sformatf("u%0d rst full", b), 32'(full[b]), 32'd0);
            chk($sformatf("u%0d rst ovf", b), 32'(ovf[b]), 32'd0);
            chk($sformatf("u%0d rst udf", b), 32'(udf[b]), 32'd0);
        end
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
